clk_div_prog: RTL and testbench

Multi-channel programmable clock divider: generates `N_CH` independent square-wave enables/clocks from one input clock, each with a runtime-loadable half-period, per-channel enable, and a one-cycle rising-edge tick. Replaces fixed single-output dividers in the display-scan, debounce and blink-rate paths. Divisor changes take effect only at a half-period boundary, so outputs never glitch or produce a runt pulse.

---
 rtl/clk_div_prog_if.sv | 16 +
 rtl/clk_div_prog.sv | 77 +++++++
 tb/tb_clk_div_prog.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: run enables, divisor-load handshake and per-channel outputs of clk_div_prog
interface clk_div_prog_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 27
);
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
  logic [N_CH-1:0]  en;
  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_ready;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  modport master (output en, cfg_valid, cfg_ch, cfg_half, input cfg_ready, clk_out, tick);
  modport slave (input en, cfg_valid, cfg_ch, cfg_half, output cfg_ready, clk_out, tick);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: N_CH programmable glitch-free clock dividers; CLKDIV_SYNC_EN adds a sync input for phase alignment
module clk_div_prog #(
  parameter int N_CH         = 4,
  parameter int FREQ_IN      = 100000000,
  parameter int FREQ_OUT     = 30,
  parameter int DIV_W        = 27,
  parameter int DEFAULT_HALF = FREQ_IN / (2 * FREQ_OUT)
) (
  input logic clk_in,
  input logic reset,
`ifdef CLKDIV_SYNC_EN
  input logic sync,
`endif
  clk_div_prog_if.slave bus
);
  logic [N_CH-1:0] w_pend;
  logic            w_sync;
`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif
  // out-of-range channel numbers are always accepted and simply dropped
  assign bus.cfg_ready = (32'(bus.cfg_ch) < N_CH) ? ~w_pend[bus.cfg_ch] : 1'b1;
  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      logic [DIV_W-1:0] r_cnt, r_half, r_pend_val;
      logic             r_pend, r_clk, r_tick;
      logic [DIV_W-1:0] w_hm1;
      logic             w_bound, w_load;
      // a half-period of 0 is treated as 1 so the counter always wraps
      assign w_hm1   = (r_half == '0) ? '0 : r_half - DIV_W'(1);
      assign w_bound = r_cnt == w_hm1;
      assign w_load  = bus.cfg_valid && bus.cfg_ready && (32'(bus.cfg_ch) == g);
      assign w_pend[g]      = r_pend;
      assign bus.clk_out[g] = r_clk;
      assign bus.tick[g]    = r_tick;
      // counter, output toggle and deferred divisor update; new half only lands on a boundary or while idle
      always_ff @(posedge clk_in) begin
        if (reset) begin
          r_cnt      <= '0;
          r_half     <= DIV_W'(DEFAULT_HALF);
          r_pend_val <= '0;
          r_pend     <= 1'b0;
          r_clk      <= 1'b0;
          r_tick     <= 1'b0;
        end else begin
          if (w_load) begin
            r_pend     <= 1'b1;
            r_pend_val <= bus.cfg_half;
          end
          if (w_sync || !bus.en[g]) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            if (r_pend) begin
              r_half <= r_pend_val;
              r_pend <= 1'b0;
            end
          end else if (w_bound) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            r_tick <= ~r_clk;
            if (r_pend) begin
              r_half <= r_pend_val;
              r_pend <= 1'b0;
            end
          end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= 1'b0;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed table and sequence checks of clk_div_prog with H=10 at reset
module tb_clk_div_prog;
  localparam int N_CH  = 4;
  localparam int DIV_W = 27;
  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef CLKDIV_SYNC_EN
  logic sync = 1'b0;
`endif
  clk_div_prog_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();
  clk_div_prog #(
    .N_CH(N_CH), .FREQ_IN(1000), .FREQ_OUT(50), .DIV_W(DIV_W)
  ) dut (
    .clk_in(clk),
    .reset(reset),
`ifdef CLKDIV_SYNC_EN
    .sync(sync),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {
    int         cyc;
    logic [3:0] clk_e;
    logic [3:0] tick_e;
  } vec_t;
  vec_t v[10];
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit found;
    v[0] = '{1, 4'h0, 4'h0};
    v[1] = '{9, 4'h0, 4'h0};
    v[2] = '{10, 4'hF, 4'hF};
    v[3] = '{11, 4'hF, 4'h0};
    v[4] = '{19, 4'hF, 4'h0};
    v[5] = '{20, 4'h0, 4'h0};
    v[6] = '{29, 4'h0, 4'h0};
    v[7] = '{30, 4'hF, 4'hF};
    v[8] = '{31, 4'hF, 4'h0};
    v[9] = '{50, 4'hF, 4'hF};
    bus.en = 4'hF;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = 2'd0;
    bus.cfg_half = '0;
    step(3);
    chk("reset clk_out", 32'(bus.clk_out), 32'h0);
    chk("reset tick", 32'(bus.tick), 32'h0);
    chk("reset cfg_ready", 32'(bus.cfg_ready), 32'h1);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      step(v[i].cyc - cyc);
      chk($sformatf("vec%0d clk_out", i), 32'(bus.clk_out), 32'(v[i].clk_e));
      chk($sformatf("vec%0d tick", i), 32'(bus.tick), 32'(v[i].tick_e));
    end
    // ch1 reload to H=3 while cnt=4 in a high phase
    step(4);
    bus.cfg_ch = 2'd1;
    chk("ld ready before", 32'(bus.cfg_ready), 32'h1);
    bus.cfg_valid = 1'b1;
    bus.cfg_half = 27'd3;
    step(1);
    bus.cfg_valid = 1'b0;
    chk("ld ready pending", 32'(bus.cfg_ready), 32'h0);
    bus.cfg_ch = 2'd0;
    #1;
    chk("ld ready other ch", 32'(bus.cfg_ready), 32'h1);
    bus.cfg_ch = 2'd1;
    step(59 - cyc);
    chk("ld old half held", 32'(bus.clk_out[1]), 32'h1);
    chk("ld ready still low", 32'(bus.cfg_ready), 32'h0);
    step(1);
    chk("ld old boundary", 32'(bus.clk_out[1]), 32'h0);
    chk("ld ready after apply", 32'(bus.cfg_ready), 32'h1);
    step(2);
    chk("ld low 3", 32'(bus.clk_out[1]), 32'h0);
    step(1);
    chk("ld rise clk", 32'(bus.clk_out[1]), 32'h1);
    chk("ld rise tick", 32'(bus.tick[1]), 32'h1);
    step(1);
    chk("ld tick clears", 32'(bus.tick[1]), 32'h0);
    step(2);
    chk("ld fall", 32'(bus.clk_out[1]), 32'h0);
    step(3);
    chk("ld rise2 tick", 32'(bus.tick[1]), 32'h1);
    // H=0 on ch0 and H=1 on ch2, loaded while those channels are disabled
    bus.en = 4'b1010;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 2'd0;
    bus.cfg_half = 27'd0;
    step(1);
    bus.cfg_ch = 2'd2;
    bus.cfg_half = 27'd1;
    step(1);
    bus.cfg_valid = 1'b0;
    step(1);
    chk("h01 idle clk", 32'({bus.clk_out[2], bus.clk_out[0]}), 32'h0);
    bus.en = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("h01 clk k%0d", k), 32'({bus.clk_out[2], bus.clk_out[0]}), (k % 2) ? 32'h3 : 32'h0);
      chk($sformatf("h01 tick k%0d", k), 32'({bus.tick[2], bus.tick[0]}), (k % 2) ? 32'h3 : 32'h0);
    end
    // drop en[3] in the middle of a high phase, then re-enable
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (bus.tick[3]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL en3 wait: got no tick on ch3 within 40 cycles expected one");
    end
    step(3);
    chk("en3 mid high", 32'(bus.clk_out[3]), 32'h1);
    bus.en[3] = 1'b0;
    step(1);
    chk("en3 off clk", 32'(bus.clk_out[3]), 32'h0);
    chk("en3 off tick", 32'(bus.tick[3]), 32'h0);
    step(4);
    chk("en3 still off", 32'(bus.clk_out[3]), 32'h0);
    bus.en[3] = 1'b1;
    step(9);
    chk("en3 pre rise", 32'(bus.clk_out[3]), 32'h0);
    step(1);
    chk("en3 rise clk", 32'(bus.clk_out[3]), 32'h1);
    chk("en3 rise tick", 32'(bus.tick[3]), 32'h1);
    // reset while ch2 has a pending half of 5
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 2'd2;
    bus.cfg_half = 27'd5;
    step(1);
    bus.cfg_valid = 1'b0;
    chk("rst pend set", 32'(bus.cfg_ready), 32'h0);
    reset = 1'b1;
    step(2);
    chk("rst ready", 32'(bus.cfg_ready), 32'h1);
    chk("rst clk_out", 32'(bus.clk_out), 32'h0);
    reset = 1'b0;
    cyc = 0;
    step(9);
    chk("rst pre rise", 32'(bus.clk_out), 32'h0);
    step(1);
    chk("rst rise clk", 32'(bus.clk_out), 32'hF);
    chk("rst rise tick", 32'(bus.tick), 32'hF);
`ifdef CLKDIV_SYNC_EN
    bus.en = 4'b1100;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch = 2'd0;
    bus.cfg_half = 27'd4;
    step(1);
    bus.cfg_ch = 2'd1;
    bus.cfg_half = 27'd6;
    step(1);
    bus.cfg_valid = 1'b0;
    step(1);
    bus.en = 4'hF;
    step(3 + 2 * $urandom_range(0, 1) + $urandom_range(0, 7));
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("sync clk", 32'(bus.clk_out[1:0]), 32'h0);
    chk("sync tick", 32'(bus.tick[1:0]), 32'h0);
    for (int k = 1; k <= 24; k++) begin
      step(1);
      chk($sformatf("sync tick k%0d", k), 32'(bus.tick[1:0]),
          32'({(k >= 6) && ((k - 6) % 12 == 0), (k >= 4) && ((k - 4) % 8 == 0)}));
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
